fifo_level: RTL and testbench
=============================

FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 32, entry count; power of two, at least 4.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 32, data bits per entry.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(FIFO_DEPTH)+1, occupancy/threshold width.
REQ-004 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port wrdata  input  FIFO_WIDTH  write data.
REQ-007 The block SHALL have port wren  input  1  write request.
REQ-008 The block SHALL have port rden  input  1  read request (pop acknowledge in FWFT mode).
REQ-009 The block SHALL have port rddata  output  FIFO_WIDTH  read data.
REQ-010 The block SHALL have port rddata_vld  output  1  rddata qualifier.
REQ-011 The block SHALL have port afull_thresh  input  CNT_W  almost-full level.
REQ-012 The block SHALL have port aempty_thresh  input  CNT_W  almost-empty level.
REQ-013 The block SHALL have port count  output  CNT_W  current occupancy.
REQ-014 The block SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 The block SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-016 The block SHALL have port clr_err  input  1  clears overflow/underflow.

Function
REQ-017 The block SHALL accept a write iff wren=1 and full=1'b0 at the clock edge; the word is stored at the write pointer, which advances modulo FIFO_DEPTH.
REQ-018 The block SHALL accept a read iff rden=1 and empty=1'b0; the read pointer advances modulo FIFO_DEPTH.
REQ-019 The block SHALL update count one edge after acceptance: +1 write only, -1 read only, unchanged for both or neither.
REQ-020 When full, simultaneous wren and rden SHALL accept the read and reject the write.
REQ-021 When empty, simultaneous wren and rden SHALL accept the write and reject the read.
REQ-022 The block SHALL drive full=(count==FIFO_DEPTH) and empty=(count==0) combinationally from registered count.
REQ-023 The block SHALL drive almost_full=(count>=afull_thresh) and almost_empty=(count<=aempty_thresh), with thresholds sampled live each cycle.
REQ-024 A rejected write SHALL set overflow at the next edge; a rejected read SHALL set underflow at the next edge.
REQ-025 Flags SHALL remain set until clr_err=1; a same-cycle new error and clr_err SHALL leave the flag set.
REQ-026 Standard mode: rddata SHALL be registered and present the popped word one cycle after the accepted read, with rddata_vld high for exactly that cycle.
REQ-027 Standard mode: rddata SHALL hold its last value when no read is accepted.
REQ-028 Pointer wrap SHALL be transparent: data order is preserved across any number of wraps.

Reset
REQ-029 While resetn=0 at an edge, the block SHALL clear pointers, count, overflow, underflow, rddata_vld and rddata to 0, giving empty=1, full=0.
REQ-030 Reset mid-operation SHALL discard all stored entries and ignore the same-cycle wren/rden; memory contents are not cleared.

Configuration
REQ-031 With macro FIFO_LEVEL_FWFT_EN defined, the block SHALL use first-word-fall-through: rddata shows the head entry combinationally, rddata_vld=!empty, rden pops.
REQ-032 In FWFT mode, a word written into an empty FIFO SHALL appear on rddata with rddata_vld=1 one cycle after its write edge.
REQ-033 Without FIFO_LEVEL_FWFT_EN, the block SHALL use standard mode per REQ-026/027.

Structure
REQ-034 Shared package fifo_pkg SHALL hold the count-width function and the error-flag bit positions.
REQ-035 Storage SHALL be a sub-module fifo_level_ram (simple dual-port, one write port, one read port, parametrised depth/width).

Verification (FIFO_DEPTH=4, FIFO_WIDTH=8)
REQ-036 Write 0x11,0x22,0x33,0x44 -> count=4, full=1; 5th write 0x55 -> rejected, overflow=1; four reads return 0x11..0x44 in order.
REQ-037 Read when empty -> underflow=1, count stays 0; clr_err pulse -> underflow=0 next cycle.
REQ-038 afull_thresh=3, aempty_thresh=1: counts 0..4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1.
REQ-039 Full plus wren and rden same cycle -> head word read, write dropped, count=3, overflow=1; empty plus both -> write kept, count=1, underflow=1.
REQ-040 Stream 10 words with interleaved reads (pointers wrap twice) -> output order equals input; resetn=0 at count=2 -> empty=1, count=0 next cycle.
REQ-041 FWFT build: write 0xA5 to empty -> next cycle rddata=0xA5, rddata_vld=1 with no rden; rden -> empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_level: occupancy-width helper and error-flag bit positions.
package fifo_pkg;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
  localparam int unsigned ERR_W   = 2;

  // One extra bit so a completely full FIFO (count == depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// Simple dual-port storage for fifo_level: synchronous write, combinational read.
module fifo_level_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_LEVEL_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  wren,
  input  logic                  rden,
  output logic [FIFO_WIDTH-1:0] rddata,
  output logic                  rddata_vld,
  input  logic [CNT_W-1:0]      afull_thresh,
  input  logic [CNT_W-1:0]      aempty_thresh,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [ERR_W-1:0]      r_err, w_err_d;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;
  logic [FIFO_WIDTH-1:0] w_ram_rdata;

  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // Gating on the registered flags alone gives read priority when full, write when empty.
  assign w_wr_acc = wren & ~w_full;
  assign w_rd_acc = rden & ~w_empty;

  always_comb begin
    w_err_d          = r_err;
    // A new error wins over a same-cycle clear.
    w_err_d[ERR_OVF] = (wren & w_full) | (r_err[ERR_OVF] & ~clr_err);
    w_err_d[ERR_UDF] = (rden & w_empty) | (r_err[ERR_UDF] & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else begin
      r_err <= w_err_d;
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_level_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (wrdata),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

`ifdef FIFO_LEVEL_FWFT_EN
  assign rddata     = w_ram_rdata;
  assign rddata_vld = ~w_empty;
`else
  logic [FIFO_WIDTH-1:0] r_rddata;
  logic                  r_rddata_vld;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rddata     <= '0;
      r_rddata_vld <= 1'b0;
    end else begin
      r_rddata_vld <= w_rd_acc;
      if (w_rd_acc) r_rddata <= w_ram_rdata;
    end
  end

  assign rddata     = r_rddata;
  assign rddata_vld = r_rddata_vld;
`endif

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= afull_thresh);
  assign almost_empty = (r_count <= aempty_thresh);
  assign overflow     = r_err[ERR_OVF];
  assign underflow    = r_err[ERR_UDF];

endmodule

// File: tb/tb_fifo_level.sv
// Directed plus random bench for fifo_level (standard read mode, depth 4, width 8).
module tb_fifo_level;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] wrdata;
  logic             wren, rden, clr_err;
  logic [WIDTH-1:0] rddata;
  logic             rddata_vld;
  logic [CW-1:0]    afull_thresh, aempty_thresh, count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] m_rd;
  logic             m_vld, m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_level #(
    .FIFO_DEPTH (DEPTH),
    .FIFO_WIDTH (WIDTH),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wrdata        (wrdata),
    .wren          (wren),
    .rden          (rden),
    .rddata        (rddata),
    .rddata_vld    (rddata_vld),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    n = sb_q.size();
    check({ctx, ":count"},  32'(count), 32'(n));
    check({ctx, ":full"},   32'(full), 32'(n == DEPTH));
    check({ctx, ":empty"},  32'(empty), 32'(n == 0));
    check({ctx, ":afull"},  32'(almost_full), 32'(n >= int'(afull_thresh)));
    check({ctx, ":aempty"}, 32'(almost_empty), 32'(n <= int'(aempty_thresh)));
    check({ctx, ":ovf"},    32'(overflow), 32'(m_ovf));
    check({ctx, ":udf"},    32'(underflow), 32'(m_udf));
    check({ctx, ":vld"},    32'(rddata_vld), 32'(m_vld));
    check({ctx, ":rddata"}, 32'(rddata), 32'(m_rd));
  endtask

  // Drive one cycle; the scoreboard decides acceptance from its own occupancy.
  task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] d,
                      input logic clr, input string ctx);
    logic wa, ra, novf, nudf;
    wren = we; rden = re; wrdata = d; clr_err = clr;
    wa   = we && (sb_q.size() < DEPTH);
    ra   = re && (sb_q.size() > 0);
    novf = (we && !wa) || (m_ovf && !clr);
    nudf = (re && !ra) || (m_udf && !clr);
    if (ra) m_rd = sb_q.pop_front();
    if (wa) sb_q.push_back(d);
    @(posedge clk);
    #1;
    m_ovf = novf; m_udf = nudf; m_vld = ra;
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    check_all(ctx);
  endtask

  // Reset with both requests asserted; they must be ignored.
  task automatic do_reset(input string ctx);
    resetn = 1'b0; wren = 1'b1; rden = 1'b1; wrdata = 8'hEE;
    @(posedge clk);
    #1;
    resetn = 1'b1; wren = 1'b0; rden = 1'b0;
    sb_q.delete();
    m_rd = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    resetn = 1'b0; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; wrdata = '0;
    afull_thresh = 3'd3; aempty_thresh = 3'd1;
    @(posedge clk);
    do_reset("reset");
    check("reset_empty", 32'(empty), 32'd1);

    // Fill to full; flag tables follow counts 1..4
    check("ae_c0", 32'(almost_empty), 32'd1);
    check("af_c0", 32'(almost_full),  32'd0);
    step(1, 0, 8'h11, 0, "w11");
    check("ae_c1", 32'(almost_empty), 32'd1);
    step(1, 0, 8'h22, 0, "w22");
    check("ae_c2", 32'(almost_empty), 32'd0);
    check("af_c2", 32'(almost_full),  32'd0);
    step(1, 0, 8'h33, 0, "w33");
    check("af_c3", 32'(almost_full),  32'd1);
    step(1, 0, 8'h44, 0, "w44");
    check("full4", 32'(full), 32'd1);
    check("af_c4", 32'(almost_full),  32'd1);
    step(1, 0, 8'h55, 0, "w55_rej");
    check("ovf_set", 32'(overflow), 32'd1);
    step(0, 1, 8'h00, 0, "r1");
    check("rd_first", 32'(rddata), 32'h11);
    step(0, 1, 8'h00, 0, "r2");
    step(0, 1, 8'h00, 0, "r3");
    step(0, 1, 8'h00, 0, "r4");
    check("rd_last", 32'(rddata), 32'h44);
    step(0, 0, 8'h00, 0, "hold");
    check("rd_hold", 32'(rddata), 32'h44);

    // Underflow, clear, and error-vs-clear priority
    step(0, 1, 8'h00, 0, "r_empty");
    check("udf_set", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1, "clr");
    check("udf_clr", 32'(underflow), 32'd0);
    step(0, 1, 8'h00, 1, "udf_and_clr");
    check("udf_wins", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1, "clr2");

    // Simultaneous access at full and empty
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h61 + i), 0, "fill");
    step(1, 1, 8'h99, 0, "full_both");
    check("full_both_cnt", 32'(count), 32'd3);
    check("full_both_rd",  32'(rddata), 32'h61);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, "drain");
    step(1, 1, 8'h77, 1, "empty_both");
    check("empty_both_cnt", 32'(count), 32'd1);
    check("empty_both_udf", 32'(underflow), 32'd1);
    step(0, 1, 8'h00, 1, "rd77");
    check("rd77", 32'(rddata), 32'h77);

    // Streaming through several pointer wraps
    step(1, 0, 8'hA0, 0, "s_pre0");
    step(1, 0, 8'hA1, 0, "s_pre1");
    for (int i = 2; i < 12; i++) step(1, 1, 8'(8'hA0 + i), 0, "stream");
    step(0, 1, 8'h00, 0, "s_post0");
    step(0, 1, 8'h00, 0, "s_post1");
    check("stream_last", 32'(rddata), 32'hAB);

    // Reset at count 2
    step(1, 0, 8'hC1, 0, "pre_rst0");
    step(1, 0, 8'hC2, 0, "pre_rst1");
    do_reset("mid_reset");
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);

    // Random traffic with live thresholds
    for (int i = 0; i < 300; i++) begin
      afull_thresh  = 3'($urandom_range(0, 7));
      aempty_thresh = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
